// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory among N requesters.
// Each grant occupies one ACCESS cycle and is followed by a one-cycle ack pulse.
module mem_arbiter #(
  parameter int N          = 2,
  parameter int WIDTH      = 8,
  parameter int LENGTH     = 256,
  parameter int ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            we,
  input  logic [N*ADDR_WIDTH-1:0] addr,
  input  logic [N*WIDTH-1:0]      wdata,
  output logic [N-1:0]            ack,
  output logic [WIDTH-1:0]        rdata,
  output logic                    busy,
  output logic                    mem_wr_en,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]        mem_wd,
  input  logic [WIDTH-1:0]        mem_rd
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [N-1:0]          r_ack;
  logic [WIDTH-1:0]      r_rdata;

  logic [N-1:0]          w_eligible;
  logic                  w_found;
  logic [PW-1:0]         w_winner;
  int                    w_idx;

  // A requester still seeing its ack this cycle must not be granted again.
  assign w_eligible = req & ~r_ack;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (!w_found && w_eligible[w_idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = ACCESS;
      ACCESS:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Memory port is quiet outside ACCESS; a write is suppressed on a reset edge.
  always_comb begin
    busy      = 1'b0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    if (r_state == ACCESS) begin
      busy     = 1'b1;
      mem_addr = r_addr;
      if (r_we) begin
        mem_wr_en = ~rst;
        mem_wd    = r_wdata;
      end else begin
        mem_rd_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
    end else begin
      r_ack <= '0;
      if (r_state == IDLE && w_found) begin
        r_owner <= w_winner;
        r_we    <= we[w_winner];
        r_addr  <= addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata <= wdata[int'(w_winner)*WIDTH +: WIDTH];
      end
      if (r_state == ACCESS) begin
        r_ack <= N'(1) << r_owner;
        r_ptr <= PW'((int'(r_owner) + 1) % N);
        if (!r_we) begin
          r_rdata <= mem_rd;
        end
      end
    end
  end

  assign ack   = r_ack;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model with its own shadow memory.
module tb_mem_arbiter;

  localparam int N      = 3;
  localparam int WIDTH  = 8;
  localparam int LENGTH = 256;
  localparam int AW     = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      we;
  logic [N*AW-1:0]   addr;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]      ack;
  logic [WIDTH-1:0]  rdata;
  logic              busy;
  logic              memWrEn;
  logic              memRdEn;
  logic [AW-1:0]     memAddr;
  logic [WIDTH-1:0]  memWd;
  logic [WIDTH-1:0]  memRd;

  logic [WIDTH-1:0]  memArray [LENGTH] = '{default: '0};

  mem_arbiter #(.N(N), .WIDTH(WIDTH), .LENGTH(LENGTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_wr_en(memWrEn),
    .mem_rd_en(memRdEn), .mem_addr(memAddr), .mem_wd(memWd), .mem_rd(memRd)
  );

  // Single-port memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (memWrEn) memArray[memAddr] <= memWd;
  end
  assign memRd = memArray[memAddr];

  // Reference model state: the transaction in flight (owner -1 when none).
  int               mOwner = -1;
  logic             mWe = 1'b0;
  logic [AW-1:0]    mAddr = '0;
  logic [WIDTH-1:0] mWd = '0;
  logic [N-1:0]     mAck = '0;
  int               mPtr = 0;
  logic [WIDTH-1:0] mRdata = '0;
  logic [WIDTH-1:0] shadow [LENGTH] = '{default: '0};

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs presented this cycle.
  task automatic modelUpdate();
    logic [N-1:0] elig;
    if (rst) begin
      mOwner = -1;
      mPtr   = 0;
      mAck   = '0;
      mRdata = '0;
    end else if (mOwner >= 0) begin
      if (mWe) shadow[mAddr] = mWd;
      else     mRdata = shadow[mAddr];
      mAck         = '0;
      mAck[mOwner] = 1'b1;
      mPtr         = (mOwner + 1) % N;
      mOwner       = -1;
    end else begin
      elig = req & ~mAck;
      mAck = '0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mPtr + k) % N;
        if (mOwner < 0 && elig[c]) begin
          mOwner = c;
          mWe    = we[c];
          mAddr  = addr[c*AW +: AW];
          mWd    = wdata[c*WIDTH +: WIDTH];
        end
      end
    end
  endtask

  // Checks every output against the model mid-cycle, then takes one clock edge.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput("busy", busy, mOwner >= 0);
    checkOutput("ack", ack, mAck);
    checkOutput("rdata", rdata, mRdata);
    checkOutput("mem_wr_en", memWrEn, (mOwner >= 0) && mWe && !rst);
    checkOutput("mem_rd_en", memRdEn, (mOwner >= 0) && !mWe);
    checkOutput("mem_addr", memAddr, (mOwner >= 0) ? mAddr : '0);
    if (mOwner >= 0 && mWe) checkOutput("mem_wd", memWd, mWd);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic setAccess(input int i, input logic isWrite, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] d);
    we[i]               = isWrite;
    addr[i*AW +: AW]    = a;
    wdata[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic randomTraffic(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && mAck[i]) begin
          if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
          else setAccess(i, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
                         8'($urandom));
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          setAccess(i, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
                    8'($urandom));
        end
      end
      applyStimulus();
    end
    rst = 1'b0;
    req = '0;
    repeat (3) applyStimulus();
  endtask

  int nAcks;
  logic [N-1:0] prevAck;

  initial begin
    rst   = 1'b1;
    req   = '1;
    we    = '0;
    addr  = '0;
    wdata = '0;

    $display("[TB] reset with all requests high");
    @(posedge clk);
    modelUpdate();
    #1;
    applyStimulus();
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wr", memWrEn, 0);
    checkOutput("rst_rd", memRdEn, 0);

    $display("[TB] simultaneous first request");
    rst = 1'b0;
    req = 3'b011;
    setAccess(0, 1'b0, 8'h00, 8'h00);
    setAccess(1, 1'b0, 8'h00, 8'h00);
    repeat (2) applyStimulus();
    checkOutput("first_r0", ack, 3'b001);
    req = 3'b010;
    repeat (2) applyStimulus();
    checkOutput("second_r1", ack, 3'b010);
    req = '0;
    applyStimulus();

    $display("[TB] single write then read");
    req = 3'b001;
    setAccess(0, 1'b1, 8'h10, 8'hA5);
    repeat (2) applyStimulus();
    checkOutput("wr_ack", ack, 3'b001);
    req = '0;
    applyStimulus();
    req = 3'b001;
    setAccess(0, 1'b0, 8'h10, 8'h00);
    repeat (2) applyStimulus();
    checkOutput("rd_ack", ack, 3'b001);
    checkOutput("rd_data", rdata, 8'hA5);
    req = '0;
    applyStimulus();

    $display("[TB] round-robin with two held requests");
    req = 3'b011;
    setAccess(0, 1'b0, 8'h01, 8'h00);
    setAccess(1, 1'b0, 8'h02, 8'h00);
    nAcks   = 0;
    prevAck = '0;
    for (int n = 0; n < 12; n++) begin
      applyStimulus();
      if (ack != '0) begin
        nAcks++;
        if (prevAck != '0) checkOutput("rr_alternate", ack == prevAck, 0);
        prevAck = ack;
      end
    end
    checkOutput("rr_count", nAcks, 6);
    req = '0;
    repeat (2) applyStimulus();

    $display("[TB] reset during a write access");
    req = 3'b001;
    setAccess(0, 1'b1, 8'h20, 8'h11);
    repeat (2) applyStimulus();
    req = '0;
    applyStimulus();
    req = 3'b010;
    setAccess(1, 1'b1, 8'h20, 8'h3C);
    applyStimulus();
    checkOutput("rst_mid_busy", busy, 1);
    rst = 1'b1;
    applyStimulus();
    checkOutput("rst_mid_noack", ack, 0);
    rst = 1'b0;
    req = '0;
    applyStimulus();
    checkOutput("rst_mid_noack2", ack, 0);
    req = 3'b001;
    setAccess(0, 1'b0, 8'h20, 8'h00);
    repeat (2) applyStimulus();
    checkOutput("rst_mid_ack", ack, 3'b001);
    checkOutput("rst_mid_data", rdata, 8'h11);
    req = '0;
    applyStimulus();

    $display("[TB] top address write then read");
    req = 3'b010;
    setAccess(1, 1'b1, 8'hFF, 8'h7E);
    repeat (2) applyStimulus();
    checkOutput("top_wr_ack", ack, 3'b010);
    req = 3'b001;
    setAccess(0, 1'b0, 8'hFF, 8'h00);
    repeat (2) applyStimulus();
    checkOutput("top_rd_ack", ack, 3'b001);
    checkOutput("top_rd_data", rdata, 8'h7E);
    req = '0;
    applyStimulus();

    $display("[TB] random traffic");
    randomTraffic(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
